// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, flushes and redirects on exception/eret,
// then masks exceptions for a refill window. Optional stuck-stall watchdog via PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          REFILL_CYCLES = 2,
  parameter int          WDOG_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  ctrl_state,
  output logic        wdog_timeout
);

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam int          RC_W     = $clog2(REFILL_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFILL_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    REFILL = 2'b01
  } state_e;

  state_e          state_q, state_d;
  logic [RC_W-1:0] refill_cnt_q, refill_cnt_d;
  logic            exc_take;

  // Encodings 2'b10/2'b11 are unreachable and behave as RUN.
  assign exc_take   = !rst && (state_q != REFILL) && (excepttype_i != 32'h0);
  assign ctrl_state = state_q;

  always_comb begin
    stall        = 6'b000000;
    flush        = 1'b0;
    new_pc       = 32'h0;
    state_d      = state_q;
    refill_cnt_d = refill_cnt_q;
    if (rst) begin
      state_d      = RUN;
      refill_cnt_d = '0;
    end else if (exc_take) begin
      flush        = 1'b1;
      new_pc       = (excepttype_i == EXC_ERET) ? epc_i : EXC_VECTOR;
      state_d      = REFILL;
      refill_cnt_d = RC_LOAD;
    end else begin
      if (stallreq_mem)     stall = 6'b011111;
      else if (stallreq_ex) stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
      else if (stallreq_if) stall = 6'b000011;
      // The refill window only counts cycles in which the PC actually advanced.
      if (state_q == REFILL && !stall[0]) begin
        if (refill_cnt_q == '0) state_d = RUN;
        else                    refill_cnt_d = refill_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    refill_cnt_q <= refill_cnt_d;
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT) + 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            wdog_timeout_q, wdog_timeout_d;

  always_comb begin
    wdog_cnt_d     = wdog_cnt_q;
    wdog_timeout_d = wdog_timeout_q;
    if (rst) begin
      wdog_cnt_d     = '0;
      wdog_timeout_d = 1'b0;
    end else begin
      if (!stall[0] || flush)      wdog_cnt_d = '0;
      else if (wdog_cnt_q != WD_MAX) wdog_cnt_d = wdog_cnt_q + 1'b1;
      if (wdog_cnt_d == WD_MAX)    wdog_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    wdog_cnt_q     <= wdog_cnt_d;
    wdog_timeout_q <= wdog_timeout_d;
  end

  assign wdog_timeout = wdog_timeout_q;
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception/eret flush, refill window, watchdog.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state;
  logic        wdog_timeout;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .REFILL_CYCLES(2), .WDOG_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .epc_i(epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .ctrl_state(ctrl_state), .wdog_timeout(wdog_timeout)
  );

  // Inputs change 1ns after a rising edge; checks happen 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype_i = 32'h0; epc_i = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1; stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
    excepttype_i = 32'h8; epc_i = 32'h0;
    #1;
    checks++; if (stall !== 6'b0) begin failures++; $display("FAIL rst_stall got=%b exp=000000", stall); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush); end
    checks++; if (new_pc !== 32'h0) begin failures++; $display("FAIL rst_new_pc got=%h exp=0", new_pc); end
    step();
    checks++; if (ctrl_state !== 2'b00) begin failures++; $display("FAIL rst_state got=%b exp=00", ctrl_state); end
    checks++; if (wdog_timeout !== 1'b0) begin failures++; $display("FAIL rst_wdog got=%b exp=0", wdog_timeout); end
    clear_inputs();
    rst = 0;
    step();
  endtask

  task automatic test_stall_priority();
    logic [3:0] req [5];
    logic [5:0] exp [5];
    req[0] = 4'b0110; exp[0] = 6'b001111;  // {mem,ex,id,if}
    req[1] = 4'b0010; exp[1] = 6'b000111;
    req[2] = 4'b0001; exp[2] = 6'b000011;
    req[3] = 4'b1001; exp[3] = 6'b011111;
    req[4] = 4'b0000; exp[4] = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req[i];
      #1;
      checks++;
      if (stall !== exp[i] || flush !== 1'b0) begin
        failures++; $display("FAIL stall_prio[%0d] got=%b/%b exp=%b/0", i, stall, flush, exp[i]);
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_exception();
    excepttype_i = 32'h8; stallreq_mem = 1;
    #1;
    checks++;
    if (flush !== 1'b1 || stall !== 6'b0 || new_pc !== 32'h20) begin
      failures++; $display("FAIL exc_flush got=%b/%b/%h exp=1/000000/00000020", flush, stall, new_pc);
    end
    step();
    checks++; if (ctrl_state !== 2'b01) begin failures++; $display("FAIL exc_state got=%b exp=01", ctrl_state); end
    checks++; if (stall !== 6'b011111) begin failures++; $display("FAIL exc_refill_stall got=%b exp=011111", stall); end
    clear_inputs();
    step(); step();
    checks++; if (ctrl_state !== 2'b00) begin failures++; $display("FAIL exc_back_run got=%b exp=00", ctrl_state); end
  endtask

  task automatic test_eret();
    excepttype_i = 32'he; epc_i = 32'h0000_1234;
    #1;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h1234) begin
      failures++; $display("FAIL eret_pc got=%b/%h exp=1/00001234", flush, new_pc);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (flush !== 1'b0 || new_pc !== 32'h0 || ctrl_state !== 2'b01) begin
        failures++; $display("FAIL eret_mask[%0d] got=%b/%h/%b exp=0/0/01", i, flush, new_pc, ctrl_state);
      end
    end
    step();
    checks++;
    if (ctrl_state !== 2'b00 || flush !== 1'b1) begin
      failures++; $display("FAIL eret_rerun got=%b/%b exp=00/1", ctrl_state, flush);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_refill_freeze();
    excepttype_i = 32'h8;
    step();
    clear_inputs();
    stallreq_if = 1;
    #1;
    checks++; if (stall !== 6'b000011) begin failures++; $display("FAIL freeze_stall got=%b exp=000011", stall); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ctrl_state !== 2'b01) begin failures++; $display("FAIL freeze_hold[%0d] got=%b exp=01", i, ctrl_state); end
    end
    stallreq_if = 0;
    step();
    checks++; if (ctrl_state !== 2'b01) begin failures++; $display("FAIL freeze_one got=%b exp=01", ctrl_state); end
    step();
    checks++; if (ctrl_state !== 2'b00) begin failures++; $display("FAIL freeze_run got=%b exp=00", ctrl_state); end
  endtask

  task automatic test_reset_mid_refill();
    excepttype_i = 32'h8;
    step();
    clear_inputs();
    rst = 1;
    step();
    checks++; if (ctrl_state !== 2'b00) begin failures++; $display("FAIL rst_refill got=%b exp=00", ctrl_state); end
    rst = 0;
    excepttype_i = 32'h8;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rst_refill_exc got=%b exp=1", flush); end
    clear_inputs();
    step();
  endtask

  task automatic test_wdog();
`ifdef PIPE_CTRL_WDOG_EN
    stallreq_ex = 1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (wdog_timeout !== 1'b0) begin failures++; $display("FAIL wdog_3 got=%b exp=0", wdog_timeout); end
    stallreq_ex = 0;
    step();
    stallreq_ex = 1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (wdog_timeout !== 1'b1) begin failures++; $display("FAIL wdog_4 got=%b exp=1", wdog_timeout); end
    stallreq_ex = 0;
    step(); step();
    checks++; if (wdog_timeout !== 1'b1) begin failures++; $display("FAIL wdog_sticky got=%b exp=1", wdog_timeout); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (wdog_timeout !== 1'b0) begin failures++; $display("FAIL wdog_rst got=%b exp=0", wdog_timeout); end
`else
    stallreq_ex = 1;
    for (int i = 0; i < 6; i++) step();
    checks++; if (wdog_timeout !== 1'b0) begin failures++; $display("FAIL wdog_off got=%b exp=0", wdog_timeout); end
    stallreq_ex = 0;
`endif
    step();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_stall_priority();
    test_exception();
    test_eret();
    test_refill_freeze();
    test_reset_mid_refill();
    test_wdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
